// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, variable-latency imem request/valid handshake,
// one-entry stall hold buffer, redirects. HLT detection enabled by FETCH_HALT_DETECT_EN.
module fetch_unit #(
  parameter int unsigned         ADDR_W   = 16,
  parameter int unsigned         INSTR_W  = 16,
  parameter logic [ADDR_W-1:0]   RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  input  logic               imem_valid_i,
  output logic               ifid_wren_o,
  output logic               ifid_clr_o,
  output logic [INSTR_W-1:0] ifid_instr_o,
  output logic [ADDR_W-1:0]  ifid_pc_plus2_o,
  output logic               halted_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DRAIN, S_HOLD
`ifdef FETCH_HALT_DETECT_EN
    , S_HALT
`endif
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   r_hold_pc_plus2;
  logic [INSTR_W-1:0]  r_hold_instr;

  logic [ADDR_W-1:0]   w_pc_plus2;
  state_t              w_fetch_next;
  state_t              w_hold_next;

  assign w_pc_plus2 = r_pc + ADDR_W'(2);

`ifdef FETCH_HALT_DETECT_EN
  assign w_fetch_next = (imem_rdata_i[INSTR_W-1 -: 4] == 4'hF) ? S_HALT : S_FETCH;
  assign w_hold_next  = (r_hold_instr[INSTR_W-1 -: 4] == 4'hF) ? S_HALT : S_FETCH;
`else
  assign w_fetch_next = S_FETCH;
  assign w_hold_next  = S_FETCH;
`endif

  // NOTE: redirect is tested before the state case so it wins over stall and valid everywhere.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_pc            <= RESET_PC;
      r_hold_instr    <= '0;
      r_hold_pc_plus2 <= '0;
    end else if (redirect_i) begin
      r_pc    <= redirect_pc_i;
      // A request still waiting for its valid must be drained before refetching.
      r_state <= ((r_state == S_FETCH || r_state == S_DRAIN) && !imem_valid_i) ? S_DRAIN : S_FETCH;
    end else begin
      case (r_state)
        S_IDLE:  r_state <= S_FETCH;
        S_FETCH: begin
          if (imem_valid_i) begin
            if (stall_i) begin
              r_hold_instr    <= imem_rdata_i;
              r_hold_pc_plus2 <= w_pc_plus2;
              r_state         <= S_HOLD;
            end else begin
              r_pc    <= w_pc_plus2;
              r_state <= w_fetch_next;
            end
          end
        end
        S_DRAIN: if (imem_valid_i) r_state <= S_FETCH;
        S_HOLD: begin
          if (!stall_i) begin
            r_pc    <= r_hold_pc_plus2;
            r_state <= w_hold_next;
          end
        end
`ifdef FETCH_HALT_DETECT_EN
        S_HALT:  r_state <= S_HALT;
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default first, so no branch can infer a latch.
  always_comb begin
    imem_req_o      = 1'b0;
    imem_addr_o     = r_pc;
    ifid_wren_o     = ~stall_i;
    ifid_clr_o      = 1'b1;
    ifid_instr_o    = '0;
    ifid_pc_plus2_o = '0;
    halted_o        = 1'b0;
    case (r_state)
      S_IDLE:  ifid_wren_o = 1'b1;
      S_FETCH: begin
        imem_req_o = 1'b1;
        if (imem_valid_i) begin
          ifid_clr_o      = 1'b0;
          ifid_instr_o    = imem_rdata_i;
          ifid_pc_plus2_o = w_pc_plus2;
        end
      end
      S_HOLD: begin
        ifid_clr_o      = 1'b0;
        ifid_instr_o    = r_hold_instr;
        ifid_pc_plus2_o = r_hold_pc_plus2;
      end
`ifdef FETCH_HALT_DETECT_EN
      S_HALT:  halted_o = 1'b1;
`endif
      default: ;
    endcase
    if (redirect_i) begin
      ifid_wren_o     = 1'b1;
      ifid_clr_o      = 1'b1;
      ifid_instr_o    = '0;
      ifid_pc_plus2_o = '0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// checked against a program-order model of the committed instruction stream.
module tb_fetch_unit;
  localparam int AW = 16;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall_i = 1'b0;
  logic          redirect_i = 1'b0;
  logic [AW-1:0] redirect_pc_i = '0;
  logic          imem_req_o;
  logic [AW-1:0] imem_addr_o;
  logic [IW-1:0] imem_rdata_i;
  logic          imem_valid_i;
  logic          ifid_wren_o;
  logic          ifid_clr_o;
  logic [IW-1:0] ifid_instr_o;
  logic [AW-1:0] ifid_pc_plus2_o;
  logic          halted_o;

  int checks = 0;
  int errors = 0;

  int            mem_lat  = 1;
  bit            mem_rand = 1'b0;
  bit            mem_busy = 1'b0;
  int            mem_cnt  = 0;
  logic [AW-1:0] mem_addr = '0;
  logic [IW-1:0] ovr [logic [AW-1:0]];

  fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC(16'h0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .redirect_i      (redirect_i),
    .redirect_pc_i   (redirect_pc_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_rdata_i    (imem_rdata_i),
    .imem_valid_i    (imem_valid_i),
    .ifid_wren_o     (ifid_wren_o),
    .ifid_clr_o      (ifid_clr_o),
    .ifid_instr_o    (ifid_instr_o),
    .ifid_pc_plus2_o (ifid_pc_plus2_o),
    .halted_o        (halted_o)
  );

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] mem_data(input logic [AW-1:0] a);
    if (ovr.exists(a)) return ovr[a];
    return IW'(16'h1000 + a);
  endfunction

  // Instruction memory: a request seen while idle answers L cycles later with a one-cycle valid.
  // It ignores the core reset, so a request in flight at reset still answers.
  initial begin
    imem_valid_i = 1'b0;
    imem_rdata_i = '0;
    forever begin
      @(posedge clk); #1;
      imem_valid_i = 1'b0;
      imem_rdata_i = IW'($urandom);
      if (mem_busy) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          imem_valid_i = 1'b1;
          imem_rdata_i = mem_data(mem_addr);
          mem_busy     = 1'b0;
        end
      end else if (imem_req_o) begin
        mem_busy = 1'b1;
        mem_addr = imem_addr_o;
        mem_cnt  = mem_rand ? int'($urandom_range(1, 4)) : mem_lat;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk); #2;
  endtask

  task automatic do_reset(input int lat);
    rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    mem_lat = lat; mem_rand = 1'b0; ovr.delete();
    repeat (6) @(posedge clk);
    #2; rst = 1'b0;
  endtask

  task automatic wait_req(input logic [AW-1:0] a, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (imem_req_o && imem_addr_o == a) begin ok = 1'b1; break; end
      cyc();
    end
  endtask

  task automatic goto_pc(input logic [AW-1:0] a, output bit ok);
    cyc(); redirect_i = 1'b1; redirect_pc_i = a;
    cyc(); redirect_i = 1'b0;
    wait_req(a, ok);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    checks++; if ({imem_req_o, ifid_wren_o, ifid_clr_o, halted_o} !== 4'b0110) begin
      errors++; $display("FAIL reset_ctrl: got req/wren/clr/halt %b want 0110", {imem_req_o, ifid_wren_o, ifid_clr_o, halted_o}); end
    checks++; if (ifid_instr_o !== '0 || ifid_pc_plus2_o !== '0) begin
      errors++; $display("FAIL reset_payload: got %h/%h want 0000/0000", ifid_instr_o, ifid_pc_plus2_o); end
    @(posedge clk); #2; rst = 1'b0;
    @(negedge clk);
    checks++; if ({imem_req_o, ifid_wren_o, ifid_clr_o} !== 3'b011) begin
      errors++; $display("FAIL idle_ctrl: got req/wren/clr %b want 011", {imem_req_o, ifid_wren_o, ifid_clr_o}); end
    cyc(); @(negedge clk);
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 16'h0000) begin
      errors++; $display("FAIL first_fetch: got req %b addr %h want 1 0000", imem_req_o, imem_addr_o); end
  endtask

  task automatic test_basic();
    logic [AW-1:0] exp_addr;
    bit            exp_commit;
    do_reset(1);
    for (int c = 0; c < 7; c++) begin
      if (c > 0) cyc();
      @(negedge clk);
      exp_commit = (c == 2 || c == 4 || c == 6);
      checks++; if ((ifid_wren_o && !ifid_clr_o) !== exp_commit) begin
        errors++; $display("FAIL basic_commit c=%0d: got %b want %b", c, ifid_wren_o && !ifid_clr_o, exp_commit); end
      if (c >= 1) begin
        exp_addr = AW'(((c - 1) / 2) * 2);
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== exp_addr) begin
          errors++; $display("FAIL basic_addr c=%0d: got req %b addr %h want 1 %h", c, imem_req_o, imem_addr_o, exp_addr); end
      end
      if (exp_commit) begin
        checks++; if (ifid_instr_o !== IW'(16'h1000 + c - 2) || ifid_pc_plus2_o !== AW'(c)) begin
          errors++; $display("FAIL basic_payload c=%0d: got %h/%h want %h/%h", c, ifid_instr_o, ifid_pc_plus2_o, IW'(16'h1000 + c - 2), AW'(c)); end
      end
    end
  endtask

  task automatic test_stall();
    bit ok;
    do_reset(1);
    ovr[16'h0008] = 16'h1234;
    wait_req(16'h0008, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_reach: got no request to 0008 want one"); end
    cyc(); stall_i = 1'b1; @(negedge clk);
    checks++; if (ifid_wren_o !== 1'b0) begin errors++; $display("FAIL stall_capture: got wren %b want 0", ifid_wren_o); end
    for (int i = 0; i < 2; i++) begin
      cyc(); @(negedge clk);
      checks++; if (ifid_wren_o !== 1'b0 || imem_req_o !== 1'b0) begin
        errors++; $display("FAIL stall_hold%0d: got wren %b req %b want 0 0", i, ifid_wren_o, imem_req_o); end
    end
    cyc(); stall_i = 1'b0; @(negedge clk);
    checks++; if ({ifid_wren_o, ifid_clr_o} !== 2'b10 || ifid_instr_o !== 16'h1234 || ifid_pc_plus2_o !== 16'h000A) begin
      errors++; $display("FAIL stall_release: got wren/clr %b%b %h/%h want 10 1234/000a", ifid_wren_o, ifid_clr_o, ifid_instr_o, ifid_pc_plus2_o); end
    cyc(); @(negedge clk);
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 16'h000A) begin
      errors++; $display("FAIL stall_next: got req %b addr %h want 1 000a", imem_req_o, imem_addr_o); end
  endtask

  task automatic test_drain();
    do_reset(3);
    cyc(); @(negedge clk);
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 16'h0000) begin
      errors++; $display("FAIL drain_req: got req %b addr %h want 1 0000", imem_req_o, imem_addr_o); end
    cyc(); redirect_i = 1'b1; redirect_pc_i = 16'h0040; @(negedge clk);
    checks++; if ({ifid_wren_o, ifid_clr_o} !== 2'b11) begin
      errors++; $display("FAIL drain_redir: got wren/clr %b%b want 11", ifid_wren_o, ifid_clr_o); end
    cyc(); redirect_i = 1'b0; @(negedge clk);
    checks++; if (imem_req_o !== 1'b0 || ifid_clr_o !== 1'b1) begin
      errors++; $display("FAIL drain_wait: got req %b clr %b want 0 1", imem_req_o, ifid_clr_o); end
    cyc(); @(negedge clk);
    checks++; if ({imem_req_o, ifid_wren_o, ifid_clr_o} !== 3'b011) begin
      errors++; $display("FAIL drain_discard: got req/wren/clr %b want 011", {imem_req_o, ifid_wren_o, ifid_clr_o}); end
    cyc(); @(negedge clk);
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 16'h0040) begin
      errors++; $display("FAIL drain_target: got req %b addr %h want 1 0040", imem_req_o, imem_addr_o); end
    repeat (3) cyc();
    @(negedge clk);
    checks++; if ({ifid_wren_o, ifid_clr_o} !== 2'b10 || ifid_instr_o !== 16'h1040 || ifid_pc_plus2_o !== 16'h0042) begin
      errors++; $display("FAIL drain_commit: got %b%b %h/%h want 10 1040/0042", ifid_wren_o, ifid_clr_o, ifid_instr_o, ifid_pc_plus2_o); end
  endtask

  task automatic test_redirect_valid();
    do_reset(1);
    cyc();
    cyc(); redirect_i = 1'b1; redirect_pc_i = 16'h0080; @(negedge clk);
    checks++; if ({ifid_wren_o, ifid_clr_o} !== 2'b11 || ifid_instr_o !== '0) begin
      errors++; $display("FAIL rv_drop: got wren/clr %b%b instr %h want 11 0000", ifid_wren_o, ifid_clr_o, ifid_instr_o); end
    cyc(); redirect_i = 1'b0; @(negedge clk);
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 16'h0080 || ifid_clr_o !== 1'b1) begin
      errors++; $display("FAIL rv_target: got req %b addr %h clr %b want 1 0080 1", imem_req_o, imem_addr_o, ifid_clr_o); end
    cyc(); @(negedge clk);
    checks++; if ({ifid_wren_o, ifid_clr_o} !== 2'b10 || ifid_instr_o !== 16'h1080 || ifid_pc_plus2_o !== 16'h0082) begin
      errors++; $display("FAIL rv_commit: got %b%b %h/%h want 10 1080/0082", ifid_wren_o, ifid_clr_o, ifid_instr_o, ifid_pc_plus2_o); end
  endtask

  task automatic test_halt();
    bit ok;
    do_reset(1);
    ovr[16'h0030] = 16'hF000;
    goto_pc(16'h0030, ok);
    checks++; if (!ok) begin errors++; $display("FAIL halt_reach: got no request to 0030 want one"); end
    cyc(); @(negedge clk);
    checks++; if ({ifid_wren_o, ifid_clr_o} !== 2'b10 || ifid_instr_o !== 16'hF000 || ifid_pc_plus2_o !== 16'h0032) begin
      errors++; $display("FAIL halt_commit: got %b%b %h/%h want 10 f000/0032", ifid_wren_o, ifid_clr_o, ifid_instr_o, ifid_pc_plus2_o); end
`ifdef FETCH_HALT_DETECT_EN
    for (int i = 0; i < 3; i++) begin
      cyc(); @(negedge clk);
      checks++; if ({halted_o, imem_req_o, ifid_clr_o} !== 3'b101) begin
        errors++; $display("FAIL halt_state%0d: got halt/req/clr %b want 101", i, {halted_o, imem_req_o, ifid_clr_o}); end
    end
    cyc(); redirect_i = 1'b1; redirect_pc_i = 16'h0020; @(negedge clk);
    checks++; if ({halted_o, ifid_wren_o, ifid_clr_o} !== 3'b111) begin
      errors++; $display("FAIL halt_redir: got halt/wren/clr %b want 111", {halted_o, ifid_wren_o, ifid_clr_o}); end
    cyc(); redirect_i = 1'b0; @(negedge clk);
    checks++; if (halted_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 16'h0020) begin
      errors++; $display("FAIL halt_resume: got halt %b req %b addr %h want 0 1 0020", halted_o, imem_req_o, imem_addr_o); end
`else
    cyc(); @(negedge clk);
    checks++; if (halted_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 16'h0032) begin
      errors++; $display("FAIL nohalt_next: got halt %b req %b addr %h want 0 1 0032", halted_o, imem_req_o, imem_addr_o); end
    cyc(); @(negedge clk);
    checks++; if ({ifid_wren_o, ifid_clr_o} !== 2'b10 || ifid_instr_o !== 16'h1032) begin
      errors++; $display("FAIL nohalt_commit: got %b%b %h want 10 1032", ifid_wren_o, ifid_clr_o, ifid_instr_o); end
`endif
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset(1);
    goto_pc(16'hFFFE, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_reach: got no request to fffe want one"); end
    cyc(); @(negedge clk);
    checks++; if ({ifid_wren_o, ifid_clr_o} !== 2'b10 || ifid_instr_o !== 16'h0FFE || ifid_pc_plus2_o !== 16'h0000) begin
      errors++; $display("FAIL wrap_commit: got %b%b %h/%h want 10 0ffe/0000", ifid_wren_o, ifid_clr_o, ifid_instr_o, ifid_pc_plus2_o); end
    cyc(); @(negedge clk);
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 16'h0000) begin
      errors++; $display("FAIL wrap_next: got req %b addr %h want 1 0000", imem_req_o, imem_addr_o); end
  endtask

  task automatic test_reset_mid();
    do_reset(3);
    cyc();
    cyc(); rst = 1'b1; #1;
    checks++; if ({imem_req_o, ifid_wren_o, ifid_clr_o} !== 3'b011) begin
      errors++; $display("FAIL rstmid_async: got req/wren/clr %b want 011", {imem_req_o, ifid_wren_o, ifid_clr_o}); end
    cyc();
    cyc(); rst = 1'b0; @(negedge clk);
    checks++; if ({imem_req_o, ifid_wren_o, ifid_clr_o} !== 3'b011 || ifid_instr_o !== '0) begin
      errors++; $display("FAIL rstmid_stale: got req/wren/clr %b instr %h want 011 0000", {imem_req_o, ifid_wren_o, ifid_clr_o}, ifid_instr_o); end
    cyc(); @(negedge clk);
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 16'h0000) begin
      errors++; $display("FAIL rstmid_refetch: got req %b addr %h want 1 0000", imem_req_o, imem_addr_o); end
    repeat (3) cyc();
    @(negedge clk);
    checks++; if ({ifid_wren_o, ifid_clr_o} !== 2'b10 || ifid_instr_o !== 16'h1000 || ifid_pc_plus2_o !== 16'h0002) begin
      errors++; $display("FAIL rstmid_commit: got %b%b %h/%h want 10 1000/0002", ifid_wren_o, ifid_clr_o, ifid_instr_o, ifid_pc_plus2_o); end
  endtask

  // Program-order model: the next instruction owed to IF/ID is at exp_pc;
  // commits consume it in order, redirects replace it.
  task automatic test_random();
    logic [AW-1:0] exp_pc;
    int            commits;
    int            bad;
    do_reset(1);
    mem_rand = 1'b1;
    exp_pc   = 16'h0000;
    commits  = 0;
    bad      = 0;
    for (int n = 0; n < 800; n++) begin
      cyc();
      stall_i       = ($urandom_range(0, 3) == 0);
      redirect_i    = (n > 2) && ($urandom_range(0, 11) == 0);
      redirect_pc_i = AW'($urandom_range(0, 255) * 2);
      @(negedge clk);
      if (imem_req_o) begin
        checks++; if (imem_addr_o !== exp_pc) begin
          errors++; bad++; $display("FAIL rand_addr n=%0d: got %h want %h", n, imem_addr_o, exp_pc); end
      end
      if (redirect_i) begin
        checks++; if ({ifid_wren_o, ifid_clr_o} !== 2'b11) begin
          errors++; bad++; $display("FAIL rand_redir n=%0d: got wren/clr %b%b want 11", n, ifid_wren_o, ifid_clr_o); end
        exp_pc = redirect_pc_i;
      end else begin
        if (stall_i) begin
          checks++; if (ifid_wren_o !== 1'b0) begin
            errors++; bad++; $display("FAIL rand_stall n=%0d: got wren %b want 0", n, ifid_wren_o); end
        end
        if (ifid_wren_o && !ifid_clr_o) begin
          checks++; if (ifid_instr_o !== mem_data(exp_pc) || ifid_pc_plus2_o !== AW'(exp_pc + 2)) begin
            errors++; bad++; $display("FAIL rand_commit n=%0d: got %h/%h want %h/%h", n, ifid_instr_o, ifid_pc_plus2_o, mem_data(exp_pc), AW'(exp_pc + 2)); end
          exp_pc = AW'(exp_pc + 2);
          commits++;
        end
      end
      if (ifid_clr_o) begin
        checks++; if (ifid_instr_o !== '0 || ifid_pc_plus2_o !== '0) begin
          errors++; bad++; $display("FAIL rand_bubble n=%0d: got %h/%h want 0000/0000", n, ifid_instr_o, ifid_pc_plus2_o); end
      end
      checks++; if (halted_o !== 1'b0) begin
        errors++; bad++; $display("FAIL rand_halt n=%0d: got %b want 0", n, halted_o); end
      if (bad > 10) break;
    end
    redirect_i = 1'b0; stall_i = 1'b0;
    checks++; if (commits < 40) begin
      errors++; $display("FAIL rand_progress: got %0d commits want at least 40", commits); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_drain();
    test_redirect_valid();
    test_halt();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
